// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full adder walks WIDTH operand bits LSB first.
// Optional subtract mode is compiled in with `define SERIAL_SUB_EN (adds the sub port).

module fadder (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic sub_sel;
    logic fa_s;
    logic fa_co;

`ifdef SERIAL_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    fadder u_fadder (
        .s    (fa_s),
        .cout (fa_co),
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    // Subtraction is a + ~b + 1, so the forced carry-in supplies the +1.
                    b_sh_d  = sub_sel ? ~b : b;
                    carry_d = sub_sel ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_co;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl (WIDTH=16); subtract vectors run when SERIAL_SUB_EN is defined.

module tb_serial_add_ctrl;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One full operation: start pulse, latency/busy-length check, result check, hold check.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input logic tsub, input string nm,
                          input logic [W-1:0] esum, input logic ecout);
        int n;
        int bcnt;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_v; cin = ~tcin;
        n = 1;
        bcnt = 0;
        while (!done && n < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, 17);
        chk({nm, "_busy_cycles"}, bcnt, 16);
        chk({nm, "_sum"}, {16'h0, sum}, {16'h0, esum});
        chk({nm, "_cout"}, {31'h0, cout}, {31'h0, ecout});
        @(negedge clk);
        chk({nm, "_done_pulse"}, {31'h0, done}, 32'h0);
        chk({nm, "_sum_held"}, {15'h0, cout, sum}, {15'h0, ecout, esum});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] ref_v;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        int n_done;
        int n_busy;
        logic [W-1:0] first_sum;
        logic [W-1:0] second_sum;

        vecs[0] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_sum", {16'h0, sum}, 32'h0);
        chk("reset_cout", {31'h0, cout}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, 1'b0, $sformatf("vec%0d", i),
                   vecs[i].exp_sum, vecs[i].exp_cout);

        // start held high through RUN/DONE: operands changed mid-run must not affect op 1
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h0100; b = 16'h0200;
        n_done = 0;
        first_sum = '0;
        second_sum = '0;
        for (int k = 0; k < 36; k++) begin
            if (done) begin
                n_done++;
                if (n_done == 1) first_sum = sum;
                else second_sum = sum;
            end
            if (k < 35) @(negedge clk);
        end
        start = 1'b0;
        chk("hold_start_ops", n_done, 2);
        chk("hold_start_first_sum", {16'h0, first_sum}, 32'h0003);
        chk("hold_start_second_sum", {16'h0, second_sum}, 32'h0300);
        @(negedge clk);
        @(negedge clk);
        chk("hold_start_idle", {30'h0, busy, done}, 32'h0);

        // async reset in the middle of RUN
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, "pre_reset", 16'h5556, 1'b0);
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F0F; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_busy", {31'h0, busy}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_sum", {16'h0, sum}, 32'h0);
        chk("abort_cout", {31'h0, cout}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_no_busy", n_busy, 0);
        run_op(16'h00FF, 16'h0F0F, 1'b1, 1'b0, "post_reset", 16'h100F, 1'b0);

`ifdef SERIAL_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow", 16'hFFFE, 1'b0);
        run_op(16'h0009, 16'h0004, 1'b0, 1'b1, "sub_noborrow", 16'h0005, 1'b1);
        run_op(16'h0009, 16'h0004, 1'b1, 1'b0, "sub_off_add", 16'h000E, 1'b0);
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, 1'b0, "rand", ref_v[W-1:0], ref_v[W]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
